// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Flag vector layout is {lt, gt, eq, zb, za} with za at bit 0.
package alu_arb_pkg;

  localparam int FLAG_W  = 5;
  localparam int OPC_W   = 3;

  localparam int FLAG_ZA = 0;
  localparam int FLAG_ZB = 1;
  localparam int FLAG_EQ = 2;
  localparam int FLAG_GT = 3;
  localparam int FLAG_LT = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin picker: the requester that did not win
// last time takes a tie, and a lone requester always wins.
module rr_arb2 (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o,
  output logic       grant_idx_o,
  output logic       any_o
);

  always_comb begin
    any_o       = |valid_i;
    grant_idx_o = 1'b0;
    grant_o     = 2'b00;
    if (valid_i == 2'b11) begin
      grant_idx_o = ~last_grant_i;
    end else begin
      grant_idx_o = valid_i[1];
    end
    if (any_o) begin
      grant_o[grant_idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two requesters: grant in
// IDLE, drive the ALU from latched operands in ISSUE, hold the result in RESP.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREQ   = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DATA_W-1:0] req_a,
  input  logic [NREQ*DATA_W-1:0] req_b,
  input  logic [NREQ*OPC_W-1:0]  req_opcode,
  input  logic [NREQ-1:0]        req_mode,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [2*DATA_W-1:0]    rsp_data,
  output logic [FLAG_W-1:0]      rsp_flags,
  output logic [DATA_W-1:0]      alu_a,
  output logic [DATA_W-1:0]      alu_b,
  output logic [OPC_W-1:0]       alu_opcode,
  output logic                   alu_mode,
  input  logic [2*DATA_W-1:0]    alu_out,
  input  logic                   alu_za,
  input  logic                   alu_zb,
  input  logic                   alu_eq,
  input  logic                   alu_gt,
  input  logic                   alu_lt,
  output logic                   busy
);

  state_e                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic                  gnt_idx_q, gnt_idx_d;
  logic [DATA_W-1:0]     op_a_q, op_a_d;
  logic [DATA_W-1:0]     op_b_q, op_b_d;
  logic [OPC_W-1:0]      opc_q, opc_d;
  logic                  mode_q, mode_d;
  logic [2*DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [FLAG_W-1:0]     rsp_flags_q, rsp_flags_d;

  logic [1:0]            arb_grant;
  logic                  arb_idx;
  logic                  arb_any;

  rr_arb2 u_rr_arb2 (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (arb_grant),
    .grant_idx_o  (arb_idx),
    .any_o        (arb_any)
  );

  // Last grant resets to requester 1 so that requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      gnt_idx_q    <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      opc_q        <= '0;
      mode_q       <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_idx_q    <= gnt_idx_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      opc_q        <= opc_d;
      mode_q       <= mode_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_idx_d    = gnt_idx_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    opc_d        = opc_q;
    mode_d       = mode_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          state_d   = ST_ISSUE;
          gnt_idx_d = arb_idx;
          op_a_d    = arb_idx ? req_a[DATA_W +: DATA_W] : req_a[0 +: DATA_W];
          op_b_d    = arb_idx ? req_b[DATA_W +: DATA_W] : req_b[0 +: DATA_W];
          opc_d     = arb_idx ? req_opcode[OPC_W +: OPC_W] : req_opcode[0 +: OPC_W];
          mode_d    = req_mode[arb_idx];
        end
      end
      ST_ISSUE: begin
        rsp_data_d           = alu_out;
        rsp_flags_d[FLAG_ZA] = alu_za;
        rsp_flags_d[FLAG_ZB] = alu_zb;
        rsp_flags_d[FLAG_EQ] = alu_eq;
        rsp_flags_d[FLAG_GT] = alu_gt;
        rsp_flags_d[FLAG_LT] = alu_lt;
        state_d              = ST_RESP;
      end
      ST_RESP: begin
        // Only the granted requester's ready can retire the response.
        if (rsp_ready[gnt_idx_q]) begin
          last_grant_d = gnt_idx_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    busy      = (state_q != ST_IDLE);
    if (state_q == ST_IDLE) begin
      req_ready = arb_grant;
    end
    if (state_q == ST_RESP) begin
      rsp_valid[gnt_idx_q] = 1'b1;
    end
  end

  // The ALU sees the latched operands at all times, so it never glitches to zero.
  assign alu_a      = op_a_q;
  assign alu_b      = op_b_q;
  assign alu_opcode = opc_q;
  assign alu_mode   = mode_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a transaction-level reference model
// and a small combinational ALU standing in for the external datapath.
module tb_alu_arbiter;

  localparam int W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [2*W-1:0]  req_a, req_b;
  logic [5:0]      req_opcode;
  logic [2*W-1:0]  rsp_data;
  logic [4:0]      rsp_flags;
  logic [W-1:0]    alu_a, alu_b;
  logic [2:0]      alu_opcode;
  logic            alu_mode;
  logic [2*W-1:0]  alu_out;
  logic            alu_za, alu_zb, alu_eq, alu_gt, alu_lt;
  logic            busy;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(W), .NREQ(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_opcode (req_opcode),
    .req_mode   (req_mode),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_flags  (rsp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_mode   (alu_mode),
    .alu_out    (alu_out),
    .alu_za     (alu_za),
    .alu_zb     (alu_zb),
    .alu_eq     (alu_eq),
    .alu_gt     (alu_gt),
    .alu_lt     (alu_lt),
    .busy       (busy)
  );

  // Stand-in ALU: mode selects signed comparison for the lt/gt flags.
  function automatic logic [2*W-1:0] aluRes(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
    logic [2*W-1:0] za, zb;
    za = {{W{1'b0}}, a};
    zb = {{W{1'b0}}, b};
    case (op)
      3'd0:    return za + zb;
      3'd1:    return {{W{1'b0}}, a - b};
      3'd2:    return za & zb;
      3'd3:    return za | zb;
      3'd4:    return za ^ zb;
      3'd5:    return za * zb;
      3'd6:    return za << b[3:0];
      default: return {a, b};
    endcase
  endfunction

  function automatic logic [4:0] aluFlags(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic mode);
    logic lt, gt;
    lt = mode ? ($signed(a) < $signed(b)) : (a < b);
    gt = mode ? ($signed(a) > $signed(b)) : (a > b);
    return {lt, gt, a == b, b == '0, a == '0};
  endfunction

  assign alu_out = aluRes(alu_a, alu_b, alu_opcode);
  assign {alu_lt, alu_gt, alu_eq, alu_zb, alu_za} = aluFlags(alu_a, alu_b, alu_mode);

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v,
                               input logic [W-1:0] a0, input logic [W-1:0] b0,
                               input logic [2:0] op0, input logic m0,
                               input logic [W-1:0] a1, input logic [W-1:0] b1,
                               input logic [2:0] op1, input logic m1,
                               input logic [1:0] rr);
    req_valid  = v;
    req_a      = {a1, a0};
    req_b      = {b1, b0};
    req_opcode = {op1, op0};
    req_mode   = {m1, m0};
    rsp_ready  = rr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 8) begin
      tick();
      n++;
    end
    checkOutput(name, busy, 1'b0);
  endtask

  // Reference model: one outstanding operation, answered two cycles after grant.
  bit             mPending;
  int             mOwner, mAge, mLast;
  logic [W-1:0]   mA, mB;
  logic [2:0]     mOp;
  logic           mMode;
  logic [2*W-1:0] mData;
  logic [4:0]     mFlags;

  function automatic int pickWinner(input logic [1:0] v, input int last);
    if (v == 2'b11) return 1 - last;
    return v[0] ? 0 : 1;
  endfunction

  task automatic modelReset();
    mPending = 0; mOwner = 0; mAge = 0; mLast = 1;
    mA = '0; mB = '0; mOp = '0; mMode = 1'b0;
    mData = '0; mFlags = '0;
  endtask

  initial begin
    logic [1:0] expReady, expValid;
    int w;
    modelReset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        modelReset();
        checkOutput("rst_req_ready", req_ready, 2'b00);
        checkOutput("rst_rsp_valid", rsp_valid, 2'b00);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_alu_a", alu_a, '0);
      end else begin
        expReady = 2'b00;
        expValid = 2'b00;
        if (!mPending && (req_valid != 2'b00)) expReady[pickWinner(req_valid, mLast)] = 1'b1;
        if (mPending && mAge >= 2) expValid[mOwner] = 1'b1;
        checkOutput("model_req_ready", req_ready, expReady);
        checkOutput("model_rsp_valid", rsp_valid, expValid);
        checkOutput("model_busy", busy, mPending);
        checkOutput("model_alu_a", alu_a, mA);
        checkOutput("model_alu_b", alu_b, mB);
        checkOutput("model_alu_opcode", alu_opcode, mOp);
        checkOutput("model_alu_mode", alu_mode, mMode);
        if (expValid != 2'b00) begin
          checkOutput("model_rsp_data", rsp_data, mData);
          checkOutput("model_rsp_flags", rsp_flags, mFlags);
        end
      end
      @(posedge clk);
      if (!rst_n) begin
        modelReset();
      end else if (!mPending) begin
        if (req_valid != 2'b00) begin
          w        = pickWinner(req_valid, mLast);
          mPending = 1;
          mOwner   = w;
          mAge     = 1;
          mA       = req_a[w*W +: W];
          mB       = req_b[w*W +: W];
          mOp      = req_opcode[w*3 +: 3];
          mMode    = req_mode[w];
          mData    = aluRes(mA, mB, mOp);
          mFlags   = aluFlags(mA, mB, mMode);
        end
      end else if (mAge < 2) begin
        mAge++;
      end else if (rsp_ready[mOwner]) begin
        mPending = 0;
        mLast    = mOwner;
      end
    end
  end

  initial begin
    int grants[$];
    int n;
    bit seen0, seen1;

    rst_n = 1'b0;
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    tick();
    checkOutput("reset_rsp_data", rsp_data, 32'h0);
    checkOutput("reset_rsp_flags", rsp_flags, 5'b00000);
    checkOutput("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single operation on requester 0 with two-cycle response latency.
    applyStimulus(2'b01, 16'h0001, 16'h0010, 3'd0, 1'b0, 0, 0, 0, 0, 2'b00);
    #1;
    checkOutput("single_ready_same_cycle", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    #1;
    checkOutput("single_no_early_valid", rsp_valid, 2'b00);
    checkOutput("single_busy_issue", busy, 1'b1);
    tick();
    checkOutput("single_rsp_valid", rsp_valid, 2'b01);
    checkOutput("single_rsp_data", rsp_data, 32'h0000_0011);
    checkOutput("single_rsp_flags", rsp_flags, 5'b10000);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;
    checkOutput("single_back_idle", busy, 1'b0);

    // Zero operands; requester 0 also wins alone right after being served.
    applyStimulus(2'b01, 16'h0000, 16'h0000, 3'd0, 1'b0, 0, 0, 0, 0, 2'b00);
    #1;
    checkOutput("lone_req0_wins", req_ready, 2'b01);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    tick();
    checkOutput("zero_rsp_flags", rsp_flags, 5'b00111);
    checkOutput("zero_rsp_data", rsp_data, 32'h0);
    rsp_ready = 2'b01;
    tick();
    rsp_ready = 2'b00;

    // Contention from reset: grants must alternate 0,1,0,1.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(2'b11, 16'h0005, 16'h0003, 3'd1, 1'b0,
                  16'h1234, 16'h0100, 3'd5, 1'b1, 2'b11);
    n = 0;
    seen0 = 0;
    seen1 = 0;
    while (grants.size() < 4 && n < 20) begin
      #1;
      if (req_ready == 2'b01) grants.push_back(0);
      if (req_ready == 2'b10) grants.push_back(1);
      if (rsp_valid[0] && !seen0) begin
        seen0 = 1;
        checkOutput("cont_req0_data", rsp_data, 32'h0000_0002);
        checkOutput("cont_req0_flags", rsp_flags, 5'b01000);
      end
      if (rsp_valid[1] && !seen1) begin
        seen1 = 1;
        checkOutput("cont_req1_data", rsp_data, 32'h0012_3400);
        checkOutput("cont_req1_flags", rsp_flags, 5'b01000);
      end
      tick();
      n++;
    end
    checkOutput("cont_grant_count", grants.size(), 4);
    checkOutput("cont_both_served", {seen1, seen0}, 2'b11);
    if (grants.size() == 4) begin
      checkOutput("cont_grant0", grants[0], 0);
      checkOutput("cont_grant1", grants[1], 1);
      checkOutput("cont_grant2", grants[2], 0);
      checkOutput("cont_grant3", grants[3], 1);
    end
    req_valid = 2'b00;
    waitIdle("cont_drain");

    // Backpressure on requester 0 while requester 1 waits; wrong-port ready ignored.
    applyStimulus(2'b11, 16'h00FF, 16'h00FF, 3'd2, 1'b0,
                  16'h0007, 16'h0009, 3'd0, 1'b0, 2'b00);
    #1;
    checkOutput("bp_req0_granted", req_ready, 2'b01);
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      rsp_ready = (i >= 2) ? 2'b10 : 2'b00;
      #1;
      checkOutput("bp_rsp_valid_hold", rsp_valid, 2'b01);
      checkOutput("bp_rsp_data_hold", rsp_data, 32'h0000_00FF);
      checkOutput("bp_rsp_flags_hold", rsp_flags, 5'b00100);
      checkOutput("bp_req_ready_low", req_ready, 2'b00);
      tick();
    end
    rsp_ready = 2'b01;
    #1;
    checkOutput("bp_no_grant_on_ack", req_ready, 2'b00);
    tick();
    checkOutput("bp_req1_next", req_ready, 2'b10);
    tick();
    applyStimulus(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10);
    tick();
    checkOutput("bp_req1_rsp_valid", rsp_valid, 2'b10);
    checkOutput("bp_req1_rsp_data", rsp_data, 32'h0000_0010);
    waitIdle("bp_drain");
    rsp_ready = 2'b00;

    // Reset while a response is pending aborts it.
    applyStimulus(2'b01, 16'h00AA, 16'h0001, 3'd3, 1'b0, 0, 0, 0, 0, 2'b00);
    tick();
    req_valid = 2'b00;
    tick();
    checkOutput("rst_resp_pending", rsp_valid, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_rsp_valid", rsp_valid, 2'b00);
    checkOutput("rst_async_busy", busy, 1'b0);
    checkOutput("rst_async_data", rsp_data, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_no_stale_rsp", rsp_valid, 2'b00);
    end
    applyStimulus(2'b11, 16'h0002, 16'h0002, 3'd0, 1'b0,
                  16'h0003, 16'h0003, 3'd0, 1'b0, 2'b11);
    #1;
    checkOutput("rst_req0_first", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    waitIdle("final_drain");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
